// File: rtl/piradip_cdc_dst_hsk_ctrl.sv
// piradip_cdc_dst_hsk_ctrl
// Destination-side controller for an xpm_cdc_handshake built with DEST_EXT_HSK=1.
// It lives entirely in dst_clk and turns the synchronized dest_req level into a
// single-word valid/ready stream. dest_ack is held back until the consumer takes
// the word, so backpressure reaches all the way to the source domain.
// It also keeps a sticky copy of the last accepted word for register-style users.
// Optional build macro: PIRADIP_CDC_DST_STATS_EN adds a 32-bit accepted-word counter.
module piradip_cdc_dst_hsk_ctrl #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             dst_clk,
    input  logic             rst,
    input  logic             dst_req,
    input  logic [WIDTH-1:0] dst_in,
    output logic             dst_ack,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [WIDTH-1:0] dst_data_hold,
    output logic             dst_hold_ready,
`ifdef PIRADIP_CDC_DST_STATS_EN
    output logic [31:0]      xfer_count,
`endif
    output logic             proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             dst_ack_q, dst_ack_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_ready_q, hold_ready_d;
    logic             proto_err_q, proto_err_d;
    logic             accept;

    // Next-state and registered-output logic; every output comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        dst_ack_d    = dst_ack_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        hold_d       = hold_q;
        hold_ready_d = hold_ready_q;
        proto_err_d  = proto_err_q;
        accept       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                dst_ack_d = 1'b0;
                if (dst_req) begin
                    // dst_in is guaranteed stable while dst_req is high
                    m_data_d  = dst_in;
                    m_valid_d = 1'b1;
                    state_d   = ST_VALID;
                end
            end
            ST_VALID: begin
                // Source withdrew its request before we acked: flag it, but still deliver
                if (!dst_req) begin
                    proto_err_d = 1'b1;
                end
                if (m_ready) begin
                    accept       = 1'b1;
                    m_valid_d    = 1'b0;
                    dst_ack_d    = 1'b1;
                    hold_d       = m_data_q;
                    hold_ready_d = 1'b1;
                    state_d      = ST_ACK;
                end
            end
            ST_ACK: begin
                // Keep acking until the source drops its request (four-phase handshake)
                if (!dst_req) begin
                    dst_ack_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                dst_ack_d = 1'b0;
                m_valid_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge dst_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dst_ack_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            hold_q       <= RESET_VAL;
            hold_ready_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dst_ack_q    <= dst_ack_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            hold_q       <= hold_d;
            hold_ready_q <= hold_ready_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign dst_ack        = dst_ack_q;
    assign m_valid        = m_valid_q;
    assign m_data         = m_data_q;
    assign dst_data_hold  = hold_q;
    assign dst_hold_ready = hold_ready_q;
    assign proto_err      = proto_err_q;

`ifdef PIRADIP_CDC_DST_STATS_EN
    logic [31:0] xfer_count_q, xfer_count_d;

    // Accepted-word counter; wraps naturally at 2^32
    always_comb begin
        xfer_count_d = xfer_count_q;
        if (accept) begin
            xfer_count_d = xfer_count_q + 32'd1;
        end
    end

    // Counter register
    always_ff @(posedge dst_clk) begin
        if (rst) begin
            xfer_count_q <= 32'd0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_piradip_cdc_dst_hsk_ctrl.sv
// Bench for piradip_cdc_dst_hsk_ctrl: directed handshake scenarios followed by
// randomized four-phase transfers scored against a word queue.
module tb_piradip_cdc_dst_hsk_ctrl;
    localparam int          WIDTH = 32;
    localparam logic [31:0] RV    = 32'hDEAD_BEEF;

    logic             clk = 1'b0;
    logic             rst;
    logic             dst_req;
    logic [WIDTH-1:0] dst_in;
    logic             dst_ack;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] dst_data_hold;
    logic             dst_hold_ready;
    logic             proto_err;
`ifdef PIRADIP_CDC_DST_STATS_EN
    logic [31:0]      xfer_count;
`endif

    int tests = 0;
    int fails = 0;

    piradip_cdc_dst_hsk_ctrl #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
        .dst_clk        (clk),
        .rst            (rst),
        .dst_req        (dst_req),
        .dst_in         (dst_in),
        .dst_ack        (dst_ack),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .dst_data_hold  (dst_data_hold),
        .dst_hold_ready (dst_hold_ready),
`ifdef PIRADIP_CDC_DST_STATS_EN
        .xfer_count     (xfer_count),
`endif
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] last_acc;
        logic [31:0] model_cnt;
        logic        acc;
        logic        a;
        logic [31:0] q[$];

        model_cnt = 0;
        rst = 1'b1; dst_req = 1'b0; dst_in = '0; m_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: reset / idle state
        tests++;
        if (dst_data_hold !== RV) begin fails++; $error("FAIL rst_hold observed=%h expected=%h", dst_data_hold, RV); end
        tests++;
        if (dst_hold_ready !== 1'b0) begin fails++; $error("FAIL rst_hold_ready observed=%h expected=%h", dst_hold_ready, 1'b0); end
        tests++;
        if (dst_ack !== 1'b0) begin fails++; $error("FAIL rst_ack observed=%h expected=%h", dst_ack, 1'b0); end
        tests++;
        if (m_valid !== 1'b0) begin fails++; $error("FAIL rst_valid observed=%h expected=%h", m_valid, 1'b0); end
        tests++;
        if (m_data !== 32'h0) begin fails++; $error("FAIL rst_data observed=%h expected=%h", m_data, 32'h0); end
        tests++;
        if (proto_err !== 1'b0) begin fails++; $error("FAIL rst_proto observed=%h expected=%h", proto_err, 1'b0); end

        // 2: single transfer with consumer always ready
        m_ready = 1'b1;
        dst_in = 32'h1234_5678; dst_req = 1'b1;
        tick();
        tests++;
        if ({m_valid, dst_ack} !== 2'b10) begin fails++; $error("FAIL single_valid observed=%h expected=%h", {m_valid, dst_ack}, 2'b10); end
        tests++;
        if (m_data !== 32'h1234_5678) begin fails++; $error("FAIL single_data observed=%h expected=%h", m_data, 32'h1234_5678); end
        tick();
        tests++;
        if ({m_valid, dst_ack} !== 2'b01) begin fails++; $error("FAIL single_ack observed=%h expected=%h", {m_valid, dst_ack}, 2'b01); end
        model_cnt++;
        tick(); tick();
        tests++;
        if (dst_ack !== 1'b1) begin fails++; $error("FAIL single_ack_held observed=%h expected=%h", dst_ack, 1'b1); end
        dst_req = 1'b0;
        tick();
        tests++;
        if (dst_ack !== 1'b0) begin fails++; $error("FAIL single_ack_fall observed=%h expected=%h", dst_ack, 1'b0); end
        tests++;
        if (dst_data_hold !== 32'h1234_5678) begin fails++; $error("FAIL single_hold observed=%h expected=%h", dst_data_hold, 32'h1234_5678); end
        tests++;
        if (dst_hold_ready !== 1'b1) begin fails++; $error("FAIL single_hold_ready observed=%h expected=%h", dst_hold_ready, 1'b1); end

        // 3: backpressure for 20 cycles
        m_ready = 1'b0;
        dst_in = 32'hA5A5_0F0F; dst_req = 1'b1;
        tick();
        dst_in = 32'h0;  // source would not change it, but the capture must not follow
        for (int i = 0; i < 20; i++) begin
            tests++;
            if ({m_valid, dst_ack, m_data} !== {2'b10, 32'hA5A5_0F0F}) begin
                fails++;
                $error("FAIL bp_stall observed=%h expected=%h", {m_valid, dst_ack, m_data}, {2'b10, 32'hA5A5_0F0F});
            end
            tick();
        end
        m_ready = 1'b1;
        tick();
        tests++;
        if ({m_valid, dst_ack} !== 2'b01) begin fails++; $error("FAIL bp_ack observed=%h expected=%h", {m_valid, dst_ack}, 2'b01); end
        tests++;
        if (dst_data_hold !== 32'hA5A5_0F0F) begin fails++; $error("FAIL bp_hold observed=%h expected=%h", dst_data_hold, 32'hA5A5_0F0F); end
        model_cnt++;
        m_ready = 1'b0; dst_req = 1'b0;
        tick();
        tests++;
        if (dst_ack !== 1'b0) begin fails++; $error("FAIL bp_ack_fall observed=%h expected=%h", dst_ack, 1'b0); end

        // Randomized four-phase transfers against a word queue
        last_acc = 32'hA5A5_0F0F;
        for (int t = 0; t < 100; t++) begin
            int gap;
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                m_ready = 1'($urandom_range(0, 1));
                dst_in  = $urandom;
                tick();
                tests++;
                if ({m_valid, dst_ack, dst_data_hold} !== {2'b00, last_acc}) begin
                    fails++;
                    $error("FAIL rand_idle observed=%h expected=%h", {m_valid, dst_ack, dst_data_hold}, {2'b00, last_acc});
                end
            end
            w = $urandom;
            q.push_back(w);
            dst_in = w; dst_req = 1'b1;
            tick();
            tests++;
            if ({m_valid, m_data} !== {1'b1, w}) begin
                fails++;
                $error("FAIL rand_valid observed=%h expected=%h", {m_valid, m_data}, {1'b1, w});
            end
            acc = 1'b0;
            for (int c = 0; c < 60 && !acc; c++) begin
                m_ready = 1'($urandom_range(0, 1));
                a = m_valid && m_ready;
                tick();
                if (a) begin
                    acc = 1'b1;
                    last_acc = q.pop_front();
                    model_cnt++;
                    tests++;
                    if ({m_valid, dst_ack, dst_hold_ready, dst_data_hold} !== {3'b011, last_acc}) begin
                        fails++;
                        $error("FAIL rand_accept observed=%h expected=%h", {m_valid, dst_ack, dst_hold_ready, dst_data_hold}, {3'b011, last_acc});
                    end
                end else begin
                    tests++;
                    if ({m_valid, dst_ack, m_data} !== {2'b10, w}) begin
                        fails++;
                        $error("FAIL rand_wait observed=%h expected=%h", {m_valid, dst_ack, m_data}, {2'b10, w});
                    end
                end
            end
            if (!acc) begin
                tests++;
                if (acc !== 1'b1) begin fails++; $error("FAIL rand_timeout observed=%h expected=%h", acc, 1'b1); end
            end
            dst_req = 1'b0; m_ready = 1'($urandom_range(0, 1));
            tick();
            tests++;
            if (dst_ack !== 1'b0) begin fails++; $error("FAIL rand_ack_fall observed=%h expected=%h", dst_ack, 1'b0); end
        end
        tests++;
        if (q.size() !== 0) begin fails++; $error("FAIL rand_queue_empty observed=%h expected=%h", q.size(), 0); end
        tests++;
        if (proto_err !== 1'b0) begin fails++; $error("FAIL rand_proto_clean observed=%h expected=%h", proto_err, 1'b0); end
`ifdef PIRADIP_CDC_DST_STATS_EN
        tests++;
        if (xfer_count !== model_cnt) begin fails++; $error("FAIL stats_count observed=%h expected=%h", xfer_count, model_cnt); end
        force dut.xfer_count_q = 32'hFFFF_FFFF;
        tick();
        release dut.xfer_count_q;
        tick();
        tests++;
        if (xfer_count !== 32'hFFFF_FFFF) begin fails++; $error("FAIL stats_preload observed=%h expected=%h", xfer_count, 32'hFFFF_FFFF); end
        m_ready = 1'b1; dst_in = 32'h0BAD_F00D; dst_req = 1'b1;
        tick(); tick();
        tests++;
        if (xfer_count !== 32'h0) begin fails++; $error("FAIL stats_wrap observed=%h expected=%h", xfer_count, 32'h0); end
        dst_req = 1'b0; m_ready = 1'b0;
        tick();
`endif

        // 4: protocol error, request withdrawn while word pending
        m_ready = 1'b0; dst_in = 32'hCAFE_0001; dst_req = 1'b1;
        tick();
        dst_req = 1'b0;
        tick();
        tests++;
        if ({proto_err, m_valid, m_data} !== {2'b11, 32'hCAFE_0001}) begin
            fails++;
            $error("FAIL perr_set observed=%h expected=%h", {proto_err, m_valid, m_data}, {2'b11, 32'hCAFE_0001});
        end
        m_ready = 1'b1;
        tick();
        tests++;
        if ({m_valid, dst_ack, dst_data_hold} !== {2'b01, 32'hCAFE_0001}) begin
            fails++;
            $error("FAIL perr_deliver observed=%h expected=%h", {m_valid, dst_ack, dst_data_hold}, {2'b01, 32'hCAFE_0001});
        end
        m_ready = 1'b0;
        tick();
        tick();
        tests++;
        if ({proto_err, dst_ack} !== 2'b10) begin fails++; $error("FAIL perr_sticky observed=%h expected=%h", {proto_err, dst_ack}, 2'b10); end

        // 5: reset while acking with dst_req still high
        dst_in = 32'h5EED_7777; dst_req = 1'b1; m_ready = 1'b1;
        tick(); tick();
        tests++;
        if (dst_ack !== 1'b1) begin fails++; $error("FAIL mid_ack observed=%h expected=%h", dst_ack, 1'b1); end
        m_ready = 1'b0; rst = 1'b1;
        tick();
        tests++;
        if ({dst_ack, m_valid, dst_hold_ready, proto_err, dst_data_hold} !== {4'b0000, RV}) begin
            fails++;
            $error("FAIL mid_rst observed=%h expected=%h", {dst_ack, m_valid, dst_hold_ready, proto_err, dst_data_hold}, {4'b0000, RV});
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({m_valid, m_data, dst_hold_ready} !== {1'b1, 32'h5EED_7777, 1'b0}) begin
            fails++;
            $error("FAIL mid_redeliver observed=%h expected=%h", {m_valid, m_data, dst_hold_ready}, {1'b1, 32'h5EED_7777, 1'b0});
        end
        tick();
        tests++;
        if (dst_hold_ready !== 1'b0) begin fails++; $error("FAIL mid_still_not_ready observed=%h expected=%h", dst_hold_ready, 1'b0); end
        m_ready = 1'b1;
        tick();
        tests++;
        if ({dst_ack, dst_hold_ready, dst_data_hold} !== {2'b11, 32'h5EED_7777}) begin
            fails++;
            $error("FAIL mid_accept observed=%h expected=%h", {dst_ack, dst_hold_ready, dst_data_hold}, {2'b11, 32'h5EED_7777});
        end
        dst_req = 1'b0; m_ready = 1'b0;
        tick();
        tests++;
        if (dst_ack !== 1'b0) begin fails++; $error("FAIL mid_ack_fall observed=%h expected=%h", dst_ack, 1'b0); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute runtime bound
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
